// File: rtl/processor_debug_pkg.sv
// Shared types and widths for the processor debugger front-end conditioners.
package processor_debug_pkg;

    localparam int PRESS_COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/execute_button_conditioner_if.sv
// Button-side signals of the execute conditioner: raw button in, conditioned strobe/level/count out.
interface execute_button_conditioner_if;
    import processor_debug_pkg::*;

    logic                     buttonIn;
    logic                     pulseOut;
    logic                     buttonLevel;
    logic [PRESS_COUNT_W-1:0] pressCount;

    modport master (output buttonIn, input pulseOut, input buttonLevel, input pressCount);
    modport slave  (input buttonIn, output pulseOut, output buttonLevel, output pressCount);

endinterface

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input, async active-high reset to 0.
module bit_synchronizer (
    input  logic Clk,
    input  logic Rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep this a true two-stage shift; blocking would collapse it to one flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/execute_button_conditioner.sv
// Execute push-button conditioner: synchronize, debounce, one pulse per press, wrapping press counter.
// Optional auto-repeat while held is enabled by defining BUTTON_AUTOREPEAT_EN.
module execute_button_conditioner
    import processor_debug_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_PERIOD   = 10
) (
    input  logic                         Clk,
    input  logic                         Rst,
    execute_button_conditioner_if.slave  btn
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Reject out-of-range configurations at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("execute_button_conditioner: illegal parameter value");
    end

    logic                     rawIn;
    logic                     syncIn;
    btn_state_t               state;
    logic [7:0]               cnt;
    logic                     pulse_q;
    logic                     level_q;
    logic [PRESS_COUNT_W-1:0] count_q;

    assign rawIn = ACTIVE_LOW ? ~btn.buttonIn : btn.buttonIn;

    bit_synchronizer u_sync (
        .Clk (Clk),
        .Rst (Rst),
        .d   (rawIn),
        .q   (syncIn)
    );

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [15:0] RPT_DELAY_LAST  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RPT_PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

    logic [15:0] rpt_cnt;
    logic        rpt_periodic;  // 0 while waiting out the initial delay, 1 once repeating
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            count_q <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b0;
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (syncIn) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!syncIn) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= HELD;
                        cnt     <= '0;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
                        count_q <= count_q + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!syncIn) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
                        rpt_cnt      <= '0;
                        rpt_periodic <= 1'b0;
                    end else if (rpt_cnt == (rpt_periodic ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
                        rpt_cnt      <= '0;
                        rpt_periodic <= 1'b1;
                        pulse_q      <= 1'b1;
                        count_q      <= count_q + 1'b1;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back high resumes HELD silently; the press was already counted.
                    if (syncIn) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign btn.pulseOut    = pulse_q;
    assign btn.buttonLevel = level_q;
    assign btn.pressCount  = count_q;

endmodule

// File: tb/tb_execute_button_conditioner.sv
// Directed self-checking bench for execute_button_conditioner (DEBOUNCE_CYCLES=3, 20-unit clock).
`timescale 1ns/1ps
module tb_execute_button_conditioner;
    import processor_debug_pkg::*;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;

    execute_button_conditioner_if btn_if ();

    execute_button_conditioner #(
        .DEBOUNCE_CYCLES (3),
        .ACTIVE_LOW      (1'b0),
        .REPEAT_DELAY    (5),
        .REPEAT_PERIOD   (3)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .btn (btn_if)
    );

    always #10 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete within time budget");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Press for 4 samples then release for 6, long enough to return to IDLE.
    task automatic quick_press();
        btn_if.buttonIn = 1'b1;
        repeat (4) tick();
        btn_if.buttonIn = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        btn_if.buttonIn = 1'b0;
        Rst = 1'b1;
        #1;
        checks++;
        if (btn_if.pulseOut !== 1'b0 || btn_if.buttonLevel !== 1'b0 || btn_if.pressCount !== 8'd0) begin
            errors++;
            $display("FAIL reset_initial: pulse=%b level=%b count=%0d expected 0/0/0",
                     btn_if.pulseOut, btn_if.buttonLevel, btn_if.pressCount);
        end
        #24 Rst = 1'b0;
        tick();
        btn_if.buttonIn = 1'b1;
        repeat (8) tick();
        checks++;
        if (btn_if.buttonLevel !== 1'b1 || btn_if.pressCount !== 8'd1) begin
            errors++;
            $display("FAIL reset_precondition: level=%b count=%0d expected 1/1",
                     btn_if.buttonLevel, btn_if.pressCount);
        end
        btn_if.buttonIn = 1'b0;
        #7 Rst = 1'b1;
        #1;
        checks++;
        if (btn_if.pulseOut !== 1'b0 || btn_if.buttonLevel !== 1'b0 || btn_if.pressCount !== 8'd0) begin
            errors++;
            $display("FAIL reset_async: pulse=%b level=%b count=%0d expected 0/0/0",
                     btn_if.pulseOut, btn_if.buttonLevel, btn_if.pressCount);
        end
        #13 Rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (btn_if.pulseOut !== 1'b0 || btn_if.buttonLevel !== 1'b0 || btn_if.pressCount !== 8'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: pulse=%b level=%b count=%0d expected 0/0/0",
                         i, btn_if.pulseOut, btn_if.buttonLevel, btn_if.pressCount);
            end
        end
        exp_count = 0;
    endtask

    task automatic test_clean_press();
        for (int p = 0; p < 20; p++) begin
            btn_if.buttonIn = 1'b1;
            for (int e = 1; e <= 10; e++) begin
                tick();
                checks++;
                if (btn_if.pulseOut !== (e == 6)) begin
                    errors++;
                    $display("FAIL clean_press[%0d] edge %0d: pulseOut=%b expected %b",
                             p, e, btn_if.pulseOut, (e == 6));
                end
                if (e == 4) btn_if.buttonIn = 1'b0;
            end
            exp_count++;
        end
        checks++;
        if (btn_if.pressCount !== 8'(exp_count)) begin
            errors++;
            $display("FAIL clean_press_count: pressCount=%0d expected %0d", btn_if.pressCount, exp_count);
        end
    endtask

    task automatic test_glitch();
        for (int w = 1; w <= 3; w++) begin
            btn_if.buttonIn = 1'b1;
            for (int e = 1; e <= w + 10; e++) begin
                tick();
                checks++;
                if (btn_if.pulseOut !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_w%0d edge %0d: pulseOut=%b expected 0", w, e, btn_if.pulseOut);
                end
                if (e == w) btn_if.buttonIn = 1'b0;
            end
        end
        checks++;
        if (btn_if.pressCount !== 8'(exp_count)) begin
            errors++;
            $display("FAIL glitch_count: pressCount=%0d expected %0d", btn_if.pressCount, exp_count);
        end
    endtask

    task automatic test_release_bounce();
        logic exp_level;
        btn_if.buttonIn = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            tick();
            exp_level = (e >= 6 && e <= 27);
            checks++;
            if (btn_if.pulseOut !== (e == 6) || btn_if.buttonLevel !== exp_level) begin
                errors++;
                $display("FAIL release_bounce edge %0d: pulse=%b level=%b expected %b/%b",
                         e, btn_if.pulseOut, btn_if.buttonLevel, (e == 6), exp_level);
            end
            if (e == 10) btn_if.buttonIn = 1'b0;
            if (e == 12) btn_if.buttonIn = 1'b1;
            if (e == 22) btn_if.buttonIn = 1'b0;
        end
        exp_count++;
        checks++;
        if (btn_if.pressCount !== 8'(exp_count)) begin
            errors++;
            $display("FAIL release_bounce_count: pressCount=%0d expected %0d", btn_if.pressCount, exp_count);
        end
    endtask

    task automatic test_wrap_and_reset_mid_press();
        @(negedge Clk) Rst = 1'b1;
        @(negedge Clk) Rst = 1'b0;
        tick();
        for (int i = 0; i < 255; i++) quick_press();
        checks++;
        if (btn_if.pressCount !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: pressCount=%0d expected 255", btn_if.pressCount);
        end
        quick_press();
        checks++;
        if (btn_if.pressCount !== 8'd0) begin
            errors++;
            $display("FAIL wrap_0: pressCount=%0d expected 0", btn_if.pressCount);
        end
        quick_press();
        // Held press interrupted by reset while debouncing.
        btn_if.buttonIn = 1'b1;
        repeat (4) tick();
        #5 Rst = 1'b1;
        #1;
        checks++;
        if (btn_if.pulseOut !== 1'b0 || btn_if.buttonLevel !== 1'b0 || btn_if.pressCount !== 8'd0) begin
            errors++;
            $display("FAIL mid_press_reset: pulse=%b level=%b count=%0d expected 0/0/0",
                     btn_if.pulseOut, btn_if.buttonLevel, btn_if.pressCount);
        end
        @(posedge Clk);
        #4 Rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            checks++;
            if (btn_if.pulseOut !== (e == 6)) begin
                errors++;
                $display("FAIL mid_press_repress edge %0d: pulseOut=%b expected %b", e, btn_if.pulseOut, (e == 6));
            end
        end
        checks++;
        if (btn_if.pressCount !== 8'd1) begin
            errors++;
            $display("FAIL mid_press_count: pressCount=%0d expected 1", btn_if.pressCount);
        end
        btn_if.buttonIn = 1'b0;
        repeat (10) tick();
        exp_count = 1;
    endtask

    task automatic test_autorepeat();
        logic exp_pulse;
        int   h;
        btn_if.buttonIn = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick();
            h = e - 6;
            exp_pulse = (h == 0);
`ifdef BUTTON_AUTOREPEAT_EN
            if (h >= 5 && ((h - 5) % 3) == 0) exp_pulse = 1'b1;
`endif
            if (exp_pulse) exp_count++;
            checks++;
            if (btn_if.pulseOut !== exp_pulse) begin
                errors++;
                $display("FAIL autorepeat edge %0d (held cycle %0d): pulseOut=%b expected %b",
                         e, h, btn_if.pulseOut, exp_pulse);
            end
        end
        checks++;
        if (btn_if.pressCount !== 8'(exp_count)) begin
            errors++;
            $display("FAIL autorepeat_count: pressCount=%0d expected %0d", btn_if.pressCount, exp_count);
        end
        btn_if.buttonIn = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        btn_if.buttonIn = 1'b0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_release_bounce();
        test_wrap_and_reset_mid_press();
        test_autorepeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
